ucsbece154a_mc_controller: RTL and testbench

UCSBECE154A_MC_CONTROLLER -- requirements
Module: ucsbece154a_mc_controller

---
 rtl/ucsbece154a_mc_controller_pkg.sv | 53 +++++
 rtl/ucsbece154a_aludec.sv | 38 +++
 rtl/ucsbece154a_mc_controller.sv | 160 ++++++++++++++++
 tb/tb_ucsbece154a_mc_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154a_mc_controller_pkg.sv
// Shared definitions for the multicycle RV32I controller.
// Holds the FSM state encoding, the ALUOp encoding, opcode/funct3
// constants and the ALUControl / ImmSrc codes used by the controller
// and the ALU decoder.
package ucsbece154a_mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_LUI
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/ucsbece154a_aludec.sv
// ALU decoder: maps the controller's ALUOp plus instruction fields to
// the 3-bit ALUControl code.
// Ports:
//   aluop       - add / sub / decode-from-funct request
//   funct3      - instruction funct3
//   funct7b5    - instruction bit 30
//   op5         - opcode bit 5 (distinguishes R-type from I-type)
//   alu_control - ALU operation select
module ucsbece154a_aludec
  import ucsbece154a_mc_controller_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALUC_ADD;
    unique case (aluop)
      ALUOP_ADD: alu_control = ALUC_ADD;
      ALUOP_SUB: alu_control = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // addi's immediate may have bit 30 set, so sub needs op5 too
          F3_ADD:  alu_control = (funct7b5 & op5) ? ALUC_SUB : ALUC_ADD;
          F3_SLT:  alu_control = ALUC_SLT;
          F3_OR:   alu_control = ALUC_OR;
          F3_AND:  alu_control = ALUC_AND;
          default: alu_control = ALUC_ADD;
        endcase
      end
      default: alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/ucsbece154a_mc_controller.sv
// Multicycle RV32I controller: Moore FSM sequencing fetch, decode,
// memory, execute and write-back steps, plus combinational ImmSrc
// decode and an ALU decoder sub-module.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   op_i, funct3_i, funct7b5_i - instruction fields from IR
//   Zero_i                     - ALU zero flag (branch resolution)
//   PCWrite_o .. MemWrite_o    - write enables
//   AdrSrc_o, ALUSrcA_o, ALUSrcB_o, ResultSrc_o, ImmSrc_o - datapath selects
//   ALUControl_o               - ALU operation
//   illegal_o                  - unsupported opcode seen in DECODE
module ucsbece154a_mc_controller
  import ucsbece154a_mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       Zero_i,
  output logic       PCWrite_o,
  output logic       IRWrite_o,
  output logic       RegWrite_o,
  output logic       MemWrite_o,
  output logic       AdrSrc_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ResultSrc_o,
  output logic [2:0] ImmSrc_o,
  output logic [2:0] ALUControl_o,
  output logic       illegal_o
);

  state_t state, state_next;
  aluop_t aluop;
  logic   pc_update, branch, ir_write, reg_write, mem_write, illegal;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    aluop       = ALUOP_ADD;
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    illegal     = 1'b0;
    AdrSrc_o    = 1'b0;
    ALUSrcA_o   = 2'b00;
    ALUSrcB_o   = 2'b00;
    ResultSrc_o = 2'b00;
    case (state)
      S_FETCH: begin
        ir_write    = 1'b1;
        ALUSrcB_o   = 2'b10;
        ResultSrc_o = 2'b10;
        pc_update   = 1'b1;
        state_next  = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b01;
        case (op_i)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTER;
          OP_ITYPE:     state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          OP_LUI:       state_next = S_LUI;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA_o  = 2'b10;
        ALUSrcB_o  = 2'b01;
        state_next = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc_o   = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc_o = 2'b01;
        reg_write   = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc_o   = 1'b1;
        mem_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA_o  = 2'b10;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA_o  = 2'b10;
        ALUSrcB_o  = 2'b01;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA_o  = 2'b10;
        aluop      = ALUOP_SUB;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA_o  = 2'b01;
        ALUSrcB_o  = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        ResultSrc_o = 2'b11;
        reg_write   = 1'b1;
        state_next  = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (op_i)
      OP_SW:   ImmSrc_o = IMM_S;
      OP_BEQ:  ImmSrc_o = IMM_B;
      OP_JAL:  ImmSrc_o = IMM_J;
      OP_LUI:  ImmSrc_o = IMM_U;
      default: ImmSrc_o = IMM_I;
    endcase
  end

  // Enables are masked while reset is held so nothing commits during reset.
  assign PCWrite_o  = ~reset & (pc_update | (branch & Zero_i));
  assign IRWrite_o  = ~reset & ir_write;
  assign RegWrite_o = ~reset & reg_write;
  assign MemWrite_o = ~reset & mem_write;
  assign illegal_o  = ~reset & illegal;

  ucsbece154a_aludec u_aludec (
    .aluop       (aluop),
    .funct3      (funct3_i),
    .funct7b5    (funct7b5_i),
    .op5         (op_i[5]),
    .alu_control (ALUControl_o)
  );

endmodule

// File: tb/tb_ucsbece154a_mc_controller.sv
// Directed self-checking bench for the multicycle controller.
module tb_ucsbece154a_mc_controller;
  import ucsbece154a_mc_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, ir_write, reg_write, mem_write, adr_src, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src, alu_control;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  ucsbece154a_mc_controller dut (
    .clk          (clk),
    .reset        (reset),
    .op_i         (op),
    .funct3_i     (funct3),
    .funct7b5_i   (funct7b5),
    .Zero_i       (zero),
    .PCWrite_o    (pc_write),
    .IRWrite_o    (ir_write),
    .RegWrite_o   (reg_write),
    .MemWrite_o   (mem_write),
    .AdrSrc_o     (adr_src),
    .ALUSrcA_o    (alu_src_a),
    .ALUSrcB_o    (alu_src_b),
    .ResultSrc_o  (result_src),
    .ImmSrc_o     (imm_src),
    .ALUControl_o (alu_control),
    .illegal_o    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal}
  function automatic logic [17:0] p(input logic pcw, input logic irw, input logic rw,
                                    input logic mw, input logic adr, input logic [1:0] sa,
                                    input logic [1:0] sb, input logic [1:0] rs,
                                    input logic [2:0] imm, input logic [2:0] aluc,
                                    input logic ill);
    return {pcw, irw, rw, mw, adr, sa, sb, rs, imm, aluc, ill};
  endfunction

  function automatic logic [17:0] act();
    return {pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a, alu_src_b,
            result_src, imm_src, alu_control, illegal};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input state_t st, input logic [17:0] exp);
    check({tag, ".st"}, 32'(dut.state), 32'(st));
    check(tag, 32'(act()), 32'(exp));
  endtask

  task automatic chk_fetch(input string tag, input logic [2:0] imm);
    chk(tag, S_FETCH, p(1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, imm, 3'b000, 0));
  endtask

  task automatic chk_decode(input string tag, input logic [2:0] imm);
    chk(tag, S_DECODE, p(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, imm, 3'b000, 0));
  endtask

  task automatic chk_reset_enables(input string tag);
    check(tag, 32'({pc_write, ir_write, reg_write, mem_write, illegal}), 32'd0);
  endtask

  logic [2:0] r_f3   [6];
  logic       r_f7   [6];
  logic [2:0] r_aluc [6];

  initial begin
    r_f3[0] = 3'b000; r_f7[0] = 1'b1; r_aluc[0] = 3'b001;
    r_f3[1] = 3'b000; r_f7[1] = 1'b0; r_aluc[1] = 3'b000;
    r_f3[2] = 3'b110; r_f7[2] = 1'b0; r_aluc[2] = 3'b011;
    r_f3[3] = 3'b111; r_f7[3] = 1'b0; r_aluc[3] = 3'b010;
    r_f3[4] = 3'b010; r_f7[4] = 1'b0; r_aluc[4] = 3'b101;
    r_f3[5] = 3'b100; r_f7[5] = 1'b0; r_aluc[5] = 3'b000;

    reset = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    step();
    chk_reset_enables("rst0");
    step();
    chk_reset_enables("rst1");
    reset = 1'b0;
    #1;
    chk_fetch("rst_first_fetch", 3'b000);

    // lw: 5 cycles
    step(); chk_decode("lw_dec", 3'b000);
    step(); chk("lw_memadr", S_MEMADR, p(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000, 0));
    step(); chk("lw_memread", S_MEMREAD, p(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
    step(); chk("lw_memwb", S_MEMWB, p(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000, 0));
    step();

    // sw: 4 cycles
    op = 7'b0100011; #1;
    chk_fetch("sw_fetch", 3'b001);
    step(); chk_decode("sw_dec", 3'b001);
    step(); chk("sw_memadr", S_MEMADR, p(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b001, 3'b000, 0));
    step(); chk("sw_memwrite", S_MEMWRITE, p(0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 0));
    step();

    // R-type table
    for (int i = 0; i < 6; i++) begin
      op = 7'b0110011; funct3 = r_f3[i]; funct7b5 = r_f7[i]; #1;
      chk_fetch($sformatf("r%0d_fetch", i), 3'b000);
      step(); chk_decode($sformatf("r%0d_dec", i), 3'b000);
      step(); chk($sformatf("r%0d_exec", i), S_EXECUTER,
                  p(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000, r_aluc[i], 0));
      step(); chk($sformatf("r%0d_aluwb", i), S_ALUWB,
                  p(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
      step();
    end

    // addi with immediate bit 30 set must still add
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1; #1;
    chk_fetch("addi_fetch", 3'b000);
    step(); chk_decode("addi_dec", 3'b000);
    step(); chk("addi_exec", S_EXECUTEI, p(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000, 0));
    step(); chk("addi_aluwb", S_ALUWB, p(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
    step();

    // beq taken / not taken
    op = 7'b1100011; funct7b5 = 1'b0; zero = 1'b1; #1;
    chk_fetch("beqt_fetch", 3'b010);
    step(); chk_decode("beqt_dec", 3'b010);
    step(); chk("beqt_beq", S_BEQ, p(1, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b010, 3'b001, 0));
    step(); chk_fetch("beqt_back", 3'b010);
    zero = 1'b0;
    step(); chk_decode("beqn_dec", 3'b010);
    step(); chk("beqn_beq", S_BEQ, p(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b010, 3'b001, 0));
    step();

    // jal
    op = 7'b1101111; #1;
    chk_fetch("jal_fetch", 3'b011);
    step(); chk_decode("jal_dec", 3'b011);
    step(); chk("jal_jal", S_JAL, p(1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 3'b011, 3'b000, 0));
    step(); chk("jal_aluwb", S_ALUWB, p(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b011, 3'b000, 0));
    step();

    // lui: 3 cycles
    op = 7'b0110111; #1;
    chk_fetch("lui_fetch", 3'b100);
    step(); chk_decode("lui_dec", 3'b100);
    step(); chk("lui_lui", S_LUI, p(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b11, 3'b100, 3'b000, 0));
    step();

    // illegal opcode
    op = 7'b1111111; #1;
    chk_fetch("ill_fetch", 3'b000);
    step(); chk("ill_dec", S_DECODE, p(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 3'b000, 1));
    step(); chk_fetch("ill_back", 3'b000);

    // reset held 3 cycles mid-lw (in MEMREAD)
    op = 7'b0000011; #1;
    step(); step(); step();
    chk("rstmid_memread", S_MEMREAD, p(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
    reset = 1'b1; #1;
    chk_reset_enables("rstmid_hold0");
    step(); chk_reset_enables("rstmid_hold1");
    step(); chk_reset_enables("rstmid_hold2");
    step(); chk_reset_enables("rstmid_hold3");
    reset = 1'b0; #1;
    chk_fetch("rstmid_release", 3'b000);
    step(); chk_decode("rstmid_dec", 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
